// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the key event generator.
package key_event_pkg;

  // Per-key state encoding; LOCKED is the post-reset state that waits for a
  // released key before any event can be generated.
  typedef enum logic [1:0] {
    LOCKED = 2'b00,
    IDLE   = 2'b01,
    HOLD   = 2'b10,
    REPEAT = 2'b11
  } key_state_e;

  // Defaults for a 100 MHz clock: 0.5 s to the first repeat, then 0.1 s.
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/key_event_cell.sv
// One key: LOCKED/IDLE/HOLD/REPEAT state machine, hold/repeat counter and
// registered press/release/held outputs.
module key_event_cell
  import key_event_pkg::*;
#(
  parameter int   HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int   REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter logic REPEAT_EN     = 1'b1,
  parameter int   CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level,
  output logic       press,
  output logic       rel,
  output logic       held,
  output key_state_e state
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam logic [63:0] MAX_TERM = 64'(MAX_CYC - 1);

  // Reject illegal timing parameters at elaboration.
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("key_event_cell: HOLD_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("key_event_cell: REPEAT_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt_w
    $error("key_event_cell: CNT_W must be in 1..63");
  end else if ((64'd1 << CNT_W) <= MAX_TERM) begin : g_narrow_cnt
    $error("key_event_cell: CNT_W too narrow for the terminal counts");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Single registered FSM: pulses default low each cycle, release beats repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOCKED;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
      held  <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        LOCKED: begin
          held <= 1'b0;
          if (!level) state <= IDLE;
        end
        IDLE: begin
          held <= 1'b0;
          if (level) begin
            press <= 1'b1;
            held  <= 1'b1;
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!level) begin
            rel   <= 1'b1;
            held  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == HOLD_LAST) begin
            // Non-repeating keys park here with the counter saturated.
            if (REPEAT_EN) begin
              press <= 1'b1;
              cnt   <= '0;
              state <= REPEAT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!level) begin
            rel   <= 1'b1;
            held  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == REPEAT_LAST) begin
            press <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOCKED;
          held  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Turns debounced key levels into press / auto-repeat / release pulses, one
// independent cell per key. "release" is a reserved word, so that output is
// named rel. The state output exposes each key's FSM state, 2 bits per key.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int                N_KEYS        = 5,
  parameter int                HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int                REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter logic [N_KEYS-1:0] REPEAT_MASK   = N_KEYS'(5'b01111),
  parameter int                CNT_W         = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_KEYS-1:0]     level,
  output logic [N_KEYS-1:0]     press,
  output logic [N_KEYS-1:0]     rel,
  output logic [N_KEYS-1:0]     held,
  output logic [2*N_KEYS-1:0]   state
);

  if (N_KEYS < 1) begin : g_bad_n_keys
    $error("key_event_gen: N_KEYS must be >= 1");
  end

  // One cell per key; repeat enable taken from the matching mask bit.
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_state_e cell_state;

    key_event_cell #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REPEAT_EN     (REPEAT_MASK[i]),
      .CNT_W         (CNT_W)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .level (level[i]),
      .press (press[i]),
      .rel   (rel[i]),
      .held  (held[i]),
      .state (cell_state)
    );

    assign state[2*i +: 2] = cell_state;
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with short hold/repeat times.
module tb_key_event_gen;
  import key_event_pkg::*;

  localparam int N  = 5;
  localparam int HC = 8;
  localparam int RC = 4;
  localparam int W  = 3 * N;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   level = '0;
  logic [N-1:0]   press, rel, held;
  logic [2*N-1:0] state;

  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int fails     = 0;

  key_event_gen #(
    .N_KEYS        (N),
    .HOLD_CYCLES   (HC),
    .REPEAT_CYCLES (RC),
    .REPEAT_MASK   (5'b01111),
    .CNT_W         (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .level (level),
    .press (press),
    .rel   (rel),
    .held  (held),
    .state (state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after that edge,
  // then pop and compare once the DUT has updated.
  task automatic step(input string tag, input logic r, input logic [N-1:0] lv,
                      input logic [N-1:0] ep, input logic [N-1:0] er,
                      input logic [N-1:0] eh);
    logic [W-1:0] e;
    @(negedge clk);
    rst   = r;
    level = lv;
    exp_q.push_back({ep, er, eh});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++;
      fails++;
      $error("FAIL %s scoreboard empty observed=%b expected=entry", tag, press);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".press"}, {5'b0, press}, {5'b0, e[3*N-1:2*N]});
      check({tag, ".rel"},   {5'b0, rel},   {5'b0, e[2*N-1:N]});
      check({tag, ".held"},  {5'b0, held},  {5'b0, e[N-1:0]});
    end
  endtask

  initial begin
    logic [N-1:0] ep;
    logic [N-1:0] eh;
    logic [N-1:0] er;

    // Reset with key 0 held: nothing happens, key 0 stays locked.
    for (int j = 0; j < 3; j++) step("rst_hold", 1'b1, 5'b00001, 5'b0, 5'b0, 5'b0);
    check("rst_state", state, 10'b0);
    for (int j = 0; j < 20; j++) step("locked", 1'b0, 5'b00001, 5'b0, 5'b0, 5'b0);
    check("locked_state0", {8'b0, state[1:0]}, {8'b0, LOCKED});
    step("drop0", 1'b0, 5'b00000, 5'b0, 5'b0, 5'b0);
    step("drop1", 1'b0, 5'b00000, 5'b0, 5'b0, 5'b0);

    // Auto-repeat on key 0: presses at k, k+8, then every 4.
    for (int j = 0; j < 30; j++) begin
      ep = (j == 0 || (j >= HC && (j - HC) % RC == 0)) ? 5'b00001 : 5'b0;
      step($sformatf("rep0_%0d", j), 1'b0, 5'b00001, ep, 5'b0, 5'b00001);
    end
    step("rep0_rel", 1'b0, 5'b0, 5'b0, 5'b00001, 5'b0);
    step("rep0_idle", 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Masked centre key: one press, no repeats, held throughout.
    for (int j = 0; j < 30; j++) begin
      ep = (j == 0) ? 5'b10000 : 5'b0;
      step($sformatf("mask4_%0d", j), 1'b0, 5'b10000, ep, 5'b0, 5'b10000);
    end
    step("mask4_rel", 1'b0, 5'b0, 5'b0, 5'b10000, 5'b0);
    step("mask4_idle", 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Key 1 dropped exactly on the first repeat edge: release wins.
    for (int j = 0; j < HC; j++) begin
      ep = (j == 0) ? 5'b00010 : 5'b0;
      step($sformatf("edge1_%0d", j), 1'b0, 5'b00010, ep, 5'b0, 5'b00010);
    end
    step("edge1_rel", 1'b0, 5'b0, 5'b0, 5'b00010, 5'b0);
    step("edge1_idle", 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Keys 0 and 2 together; key 2 released after 5 cycles.
    for (int j = 0; j <= 10; j++) begin
      ep = (j == 0) ? 5'b00101 : ((j == HC) ? 5'b00001 : 5'b0);
      er = (j == 5) ? 5'b00100 : ((j == 10) ? 5'b00001 : 5'b0);
      eh = {2'b0, (j < 5), 1'b0, (j < 10)};
      step($sformatf("sim_%0d", j), 1'b0, {2'b0, (j < 5), 1'b0, (j < 10)}, ep, er, eh);
    end
    step("sim_idle", 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Key 3 held, reset at k+10: silent, locked until released and re-pressed.
    for (int j = 0; j < 10; j++) begin
      ep = (j == 0 || j == HC) ? 5'b01000 : 5'b0;
      step($sformatf("mid3_%0d", j), 1'b0, 5'b01000, ep, 5'b0, 5'b01000);
    end
    step("mid3_rst", 1'b1, 5'b01000, 5'b0, 5'b0, 5'b0);
    check("mid3_rst_state", state, 10'b0);
    for (int j = 0; j < 5; j++) step("mid3_locked", 1'b0, 5'b01000, 5'b0, 5'b0, 5'b0);
    check("mid3_locked_state", {8'b0, state[7:6]}, {8'b0, LOCKED});
    step("mid3_low", 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    step("mid3_press", 1'b0, 5'b01000, 5'b01000, 5'b0, 5'b01000);
    step("mid3_rel", 1'b0, 5'b0, 5'b0, 5'b01000, 5'b0);

    // Single-cycle level pulse: press and release on back-to-back cycles.
    step("blip_press", 1'b0, 5'b00100, 5'b00100, 5'b0, 5'b00100);
    step("blip_rel", 1'b0, 5'b0, 5'b0, 5'b00100, 5'b0);
    step("blip_idle", 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Converts the debounced, level-type button signals of the Gomoku board controller into one-cycle key events: a press pulse on each rising edge, an auto-repeat press train while a key is held, and a release pulse on each falling edge. It sits directly downstream of the per-button chatter-removal stages and feeds the cursor-move / stone-place logic, which acts only on single-cycle pulses. Each key is handled independently by its own state machine.

## Interface

Parameters:
- N_KEYS, 5, number of keys (up, down, left, right, centre).
- HOLD_CYCLES, 50_000_000, cycles from the initial press to the first auto-repeat; must be ≥ 2.
- REPEAT_CYCLES, 10_000_000, cycles between successive auto-repeats; must be ≥ 1.
- REPEAT_MASK, 5'b01111, per-key auto-repeat enable; bit i = 1 allows key i to repeat. Centre does not repeat by default.
- CNT_W, 26, counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, REPEAT_CYCLES) − 1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- level  in  N_KEYS  debounced key levels, already synchronous to clk; 1 = pressed.
- press  out  N_KEYS  one-cycle pulse for the initial press and for each auto-repeat.
- release  out  N_KEYS  one-cycle pulse on key release.
- held  out  N_KEYS  1 while key i is in HOLD or REPEAT.

## Operation

- Each key has one state machine with states LOCKED, IDLE, HOLD and REPEAT, and a CNT_W-bit counter.
- Reset: every state → LOCKED, every counter → 0, and press, release and held → 0.
- LOCKED:
  - Moves to IDLE when level[i] is sampled 0.
  - Never emits a pulse, so a key held through reset produces no press and no release.
- IDLE:
  - If level[i] is sampled 1: press[i] ← 1, counter ← 0, go to HOLD.
- HOLD, with level[i] = 1:
  - If counter = HOLD_CYCLES−1 and REPEAT_MASK[i] = 1: press[i] ← 1, counter ← 0, go to REPEAT.
  - If counter = HOLD_CYCLES−1 and REPEAT_MASK[i] = 0: stay in HOLD, counter saturates, no pulse.
  - Otherwise: counter increments.
- REPEAT, with level[i] = 1:
  - If counter = REPEAT_CYCLES−1: press[i] ← 1, counter ← 0.
  - Otherwise: counter increments.
- HOLD or REPEAT, with level[i] = 0:
  - release[i] ← 1, counter ← 0, go to IDLE.
  - Release takes priority: no press is emitted on that edge, even if the counter was at its terminal value.
- Counters never wrap.
- Keys are fully independent. Simultaneous edges on several keys produce simultaneous pulses.
- press[i] and release[i] are never high in the same cycle.

## Timing

- All outputs are registered; there are no combinational paths from level to the outputs.
- Let k be the clock edge at which level[i] is first sampled 1 while the key is in IDLE:
  - press[i] is high for exactly the cycle following edge k (latency 1).
  - held[i] rises at edge k.
- Auto-repeat pulses (REPEAT_MASK[i] = 1) are asserted at edges k + HOLD_CYCLES + n·REPEAT_CYCLES, for n = 0, 1, 2, …
- If level[i] is first sampled 0 at edge r:
  - release[i] is high for the cycle following edge r.
  - held[i] falls at edge r.
- A high pulse of a single cycle on level[i] gives press at edge k, then release at edge k+1, i.e. on back-to-back cycles.
- rst asserted mid-hold: at the next edge all outputs are 0 and the key is in LOCKED. No release pulse is emitted.

## Structure

- Shared package key_event_pkg:
  - The 2-bit state enum: LOCKED = 2'b00, IDLE = 2'b01, HOLD = 2'b10, REPEAT = 2'b11.
  - Default constants for HOLD_CYCLES and REPEAT_CYCLES at a 100 MHz clock.
- Sub-module key_event_cell:
  - Handles one key: FSM, counter, and the three output registers.
  - Takes HOLD_CYCLES, REPEAT_CYCLES, REPEAT_EN and CNT_W as parameters.
  - key_event_gen instantiates N_KEYS cells in a generate loop, with REPEAT_EN = REPEAT_MASK[i].
- Parameter legality (the ranges above and the CNT_W bound) is checked at elaboration.

## Test plan

The bench uses HOLD_CYCLES = 8, REPEAT_CYCLES = 4 and N_KEYS = 5.

- **Reset with key held:** hold level = 5'b00001 through rst and for 20 cycles after it.
  - Expect no press, release or held activity.
  - Drop level, wait 2 cycles, raise it at edge k: press[0] is high only in the cycle after k.
- **Auto-repeat:** hold key 0 (up) for 30 cycles from edge k.
  - press[0] pulses at k, k+8, k+12, k+16, k+20, k+24 and k+28.
  - The release pulse follows the edge at which level drops.
- **Masked key:** hold key 4 (centre) for 30 cycles.
  - Exactly one press pulse, no repeats, one release.
  - held[4] is high for all 30 cycles.
- **Release on a repeat edge:** drop level[1] at exactly edge k+8.
  - No press at k+8; release[1] high after k+8.
  - held[1] is 0 from k+8.
- **Simultaneous keys:** raise keys 0 and 2 on the same edge; release key 2 after 5 cycles.
  - Two coincident press pulses.
  - Key 0 repeats unaffected at k+8.
  - release[2] only.
- **Reset mid-repeat:** assert rst at k+10 while key 3 is held.
  - All outputs are 0 at the next edge.
  - No release pulse, and no press until key 3 goes low and then high again.
